instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage: owns the program counter, drives the word address of the synchronous
//   instruction memory, and pairs each returned word with its PC in the IF/ID register.
//   Absorbs the memory's 1-cycle read latency, stalls from decode, and redirects
//   (taken branch/jump) from execute. Sustains one instruction per cycle.
// PARAMETERS
//   SIZE_EXP2  10           instruction memory address width in words; must match the memory
//   RESET_PC   32'h0000_0000  byte address fetched first after reset; bits [1:0] must be 00
// PORTS
//   system_clock     in   1          rising-edge clock
//   system_reset_n   in   1          asynchronous, active-low reset
//   imem_address     out  SIZE_EXP2  word address to memory; data appears on imem_data next cycle
//   imem_data        in   32         memory read data for the address of the previous cycle
//   redirect_valid   in   1          execute requests a fetch restart at redirect_pc
//   redirect_pc      in   32         redirect target, byte address; bits [1:0] ignored
//   out_ready        in   1          decode accepts the IF/ID contents this cycle
//   out_valid        out  1          IF/ID register holds a valid instruction
//   out_pc           out  32         byte PC of out_instruction, bits [1:0] = 00
//   out_pc_plus4     out  32         out_pc + 4, modulo 2^32
//   out_instruction  out  32         instruction word
// BEHAVIOUR
//   - Registers:
//       fetch_pc               PC to request next
//       resp_valid, resp_pc    request in flight to memory
//       out_*                  IF/ID register
//   - Reset (asynchronous, takes effect immediately):
//       fetch_pc = RESET_PC; resp_valid = 0; resp_pc = 0; out_valid = 0
//       out_pc = 0; out_pc_plus4 = 4; out_instruction = 0 (NOP)
//   - advance = !out_valid || out_ready.
//   - imem_address, combinational, first match wins:
//       1. redirect_valid                 -> redirect_pc[SIZE_EXP2+1:2]
//       2. !advance && resp_valid (stall) -> resp_pc[SIZE_EXP2+1:2]; replays the in-flight
//          read, because the memory has no enable
//       3. otherwise                      -> fetch_pc[SIZE_EXP2+1:2]
//   - Rising edge, priority order:
//       1. redirect_valid:
//            out_valid <= 0; resp_valid <= 1; resp_pc <= {redirect_pc[31:2],2'b00}
//            fetch_pc <= that value + 4
//          Redirect beats stall: the held instruction is dropped even if out_ready = 0.
//       2. advance:
//            out_valid <= resp_valid
//            if resp_valid: out_pc <= resp_pc; out_pc_plus4 <= resp_pc + 4
//                           out_instruction <= imem_data
//            resp_valid <= 1; resp_pc <= fetch_pc; fetch_pc <= fetch_pc + 4
//       3. stall: all registers hold; out_* remain stable and valid.
//   - Latency and throughput:
//       * reset release to first out_valid = 2 rising edges
//       * redirect = exactly 1 bubble: out_valid low for 1 cycle, then the target instruction
//       * no instruction is skipped or duplicated across any stall length
//   - Arithmetic and wrap-around:
//       * PCs are 32-bit and wrap modulo 2^32
//       * imem_address truncates the PC to SIZE_EXP2 bits, so memory indices wrap silently
//       * out_pc carries the full untruncated PC
//   - Reset mid-operation: in-flight request and IF/ID discarded; fetch restarts at RESET_PC.
//   - Upper PC bits above SIZE_EXP2+1 are not range-checked.
// TESTING  (SIZE_EXP2=4; memory preloaded mem[i] = 32'h1000_0000 + i)
//   1. Reset, RESET_PC=0, out_ready=1 ->
//        out_valid=0 for the first edge after release, then every cycle
//        (pc, instr) = (0, 1000_0000), (4, 1000_0001), (8, 1000_0002), ...
//   2. out_ready=0 for 3 cycles while out_pc=8 ->
//        out_* stable; imem_address=3 throughout
//        after release: pc 12 then 16, nothing skipped or duplicated
//   3. redirect_valid=1, redirect_pc=0x20 ->
//        next edge: out_valid=0
//        then (0x20, 1000_0008), (0x24, 1000_0009)
//   4. redirect_valid=1 with out_ready=0 and out_pc=8 valid ->
//        held pc 8 is dropped; out_pc=0x20 follows after 1 bubble
//   5. RESET_PC=0x3C ->
//        (0x3C, 1000_000F), then (0x40, 1000_0000) with imem_address=0
//        out_pc_plus4 = 0x44
//   6. Reset asserted mid-stream and redirect_pc=0x43 ->
//        reset: out_valid drops without a clock edge; restart at RESET_PC
//        misaligned redirect: out_pc = 0x40

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses a 1-cycle-latency instruction memory and pairs
// each returned word with its PC in the IF/ID register, with decode stall and execute redirect.
module instruction_fetch #(
    parameter int unsigned SIZE_EXP2 = 10,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 system_clock,
    input  logic                 system_reset_n,
    output logic [SIZE_EXP2-1:0] imem_address,
    input  logic [31:0]          imem_data,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_pc_plus4,
    output logic [31:0]          out_instruction
);

    logic [31:0] r_fetch_pc;
    logic        r_resp_valid;
    logic [31:0] r_resp_pc;
    logic        r_out_valid;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_pc_plus4;
    logic [31:0] r_out_instruction;

    logic        w_advance;
    logic [31:0] w_redirect_base;

    assign w_advance       = !r_out_valid || out_ready;
    assign w_redirect_base = redirect_pc & ~32'd3;

    // Memory address select; a stall re-issues the in-flight read since the memory has no enable
    always_comb begin
        imem_address = r_fetch_pc[SIZE_EXP2+1:2];
        if (redirect_valid) begin
            imem_address = w_redirect_base[SIZE_EXP2+1:2];
        end else if (!w_advance && r_resp_valid) begin
            imem_address = r_resp_pc[SIZE_EXP2+1:2];
        end else begin
            imem_address = r_fetch_pc[SIZE_EXP2+1:2];
        end
    end

    // Fetch PC and in-flight request tracking
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_fetch_pc   <= RESET_PC;
            r_resp_valid <= 1'b0;
            r_resp_pc    <= 32'd0;
        end else if (redirect_valid) begin
            r_fetch_pc   <= w_redirect_base + 32'd4;
            r_resp_valid <= 1'b1;
            r_resp_pc    <= w_redirect_base;
        end else if (w_advance) begin
            r_fetch_pc   <= r_fetch_pc + 32'd4;
            r_resp_valid <= 1'b1;
            r_resp_pc    <= r_fetch_pc;
        end else begin
            r_fetch_pc   <= r_fetch_pc;
            r_resp_valid <= r_resp_valid;
            r_resp_pc    <= r_resp_pc;
        end
    end

    // IF/ID register; a redirect drops the held instruction even while decode stalls
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_out_valid       <= 1'b0;
            r_out_pc          <= 32'd0;
            r_out_pc_plus4    <= 32'd4;
            r_out_instruction <= 32'd0;
        end else if (redirect_valid) begin
            r_out_valid       <= 1'b0;
            r_out_pc          <= r_out_pc;
            r_out_pc_plus4    <= r_out_pc_plus4;
            r_out_instruction <= r_out_instruction;
        end else if (w_advance) begin
            r_out_valid <= r_resp_valid;
            if (r_resp_valid) begin
                r_out_pc          <= r_resp_pc;
                r_out_pc_plus4    <= r_resp_pc + 32'd4;
                r_out_instruction <= imem_data;
            end else begin
                r_out_pc          <= r_out_pc;
                r_out_pc_plus4    <= r_out_pc_plus4;
                r_out_instruction <= r_out_instruction;
            end
        end else begin
            r_out_valid       <= r_out_valid;
            r_out_pc          <= r_out_pc;
            r_out_pc_plus4    <= r_out_pc_plus4;
            r_out_instruction <= r_out_instruction;
        end
    end

    assign out_valid       = r_out_valid;
    assign out_pc          = r_out_pc;
    assign out_pc_plus4    = r_out_pc_plus4;
    assign out_instruction = r_out_instruction;

endmodule
